// File: rtl/crc8_tx_framer_if.sv
// Payload stream, framed output stream, CRC-engine handshake and error pulses
// of crc8_tx_framer. The framer uses the master view, its environment the slave view.
interface crc8_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic [7:0] crc_in;
    logic       crc_enable;
    logic       crc_clr;
    logic [7:0] crc_out;
    logic       crc_complete;
    logic       err_timeout;
    logic       err_overlen;

    modport master (
        input  s_data, s_valid, s_last, m_ready, crc_out, crc_complete,
        output s_ready, m_data, m_valid, m_last, crc_in, crc_enable, crc_clr,
               err_timeout, err_overlen
    );

    modport slave (
        output s_data, s_valid, s_last, m_ready, crc_out, crc_complete,
        input  s_ready, m_data, m_valid, m_last, crc_in, crc_enable, crc_clr,
               err_timeout, err_overlen
    );
endinterface

// File: rtl/crc8_tx_framer.sv
// Transmit framer: SOF byte, payload bytes fed one at a time through an external
// CRC-8 engine, then the engine result as trailer. Recovers from engine timeout and over-length.
module crc8_tx_framer #(
    parameter logic [7:0] SOF     = 8'h7E,
    parameter int         MAX_LEN = 255,
    parameter int         TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    crc8_tx_framer_if.master bus
);
    localparam int             TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TLIM    = TW'(TIMEOUT - 1);
    localparam logic [8:0]     LEN_LIM = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SOF, S_FEED, S_PULSE, S_WAIT, S_SEND, S_TRAIL
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_hold;
    logic [7:0]    r_latch;
    logic [7:0]    r_cnt;
    logic [TW-1:0] r_tcnt;
    logic          r_last_flag;
    logic          r_overlen_flag;
    logic          r_err_timeout;
    logic          r_err_overlen;

    logic          w_s_ready;
    logic          w_m_valid;
    logic          w_m_last;
    logic [7:0]    w_m_data;
    logic          w_crc_enable;
    logic          w_crc_clr;
    logic [8:0]    w_cnt_inc;
    logic          w_at_max;
    logic          w_tmo;

    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
    assign w_at_max  = (w_cnt_inc == LEN_LIM);
    assign w_tmo     = (r_tcnt == TLIM);

    // Outputs depend on state and registers only; inputs only steer transitions.
    always_comb begin
        w_next       = r_state;
        w_s_ready    = 1'b0;
        w_m_valid    = 1'b0;
        w_m_last     = 1'b0;
        w_m_data     = 8'h00;
        w_crc_enable = 1'b0;
        w_crc_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.s_valid) w_next = S_CLR;
            end
            S_CLR: begin
                w_crc_clr = 1'b1;
                w_next    = S_SOF;
            end
            S_SOF: begin
                w_m_valid = 1'b1;
                w_m_data  = SOF;
                if (bus.m_ready) w_next = S_FEED;
            end
            S_FEED: begin
                w_s_ready = 1'b1;
                if (bus.s_valid) w_next = S_PULSE;
            end
            S_PULSE: begin
                w_crc_enable = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                if (bus.crc_complete) w_next = S_SEND;
                else if (w_tmo)       w_next = S_IDLE;
            end
            S_SEND: begin
                w_m_valid = 1'b1;
                w_m_data  = r_hold;
                if (bus.m_ready) w_next = r_last_flag ? S_TRAIL : S_FEED;
            end
            S_TRAIL: begin
                w_m_valid = 1'b1;
                w_m_last  = 1'b1;
                w_m_data  = r_latch;
                if (bus.m_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_hold         <= 8'h00;
            r_latch        <= 8'h00;
            r_cnt          <= 8'h00;
            r_tcnt         <= '0;
            r_last_flag    <= 1'b0;
            r_overlen_flag <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overlen  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_err_timeout <= 1'b0;
            r_err_overlen <= 1'b0;
            case (r_state)
                S_CLR: r_cnt <= 8'h00;
                S_FEED: begin
                    if (bus.s_valid) begin
                        r_hold         <= bus.s_data;
                        // Reaching the length limit closes the frame even without s_last.
                        r_last_flag    <= bus.s_last | w_at_max;
                        r_overlen_flag <= w_at_max & ~bus.s_last;
                        r_cnt          <= w_cnt_inc[7:0];
                    end
                end
                S_PULSE: r_tcnt <= '0;
                S_WAIT: begin
                    if (bus.crc_complete) r_latch       <= bus.crc_out;
                    else if (w_tmo)       r_err_timeout <= 1'b1;
                    else                  r_tcnt        <= r_tcnt + 1'b1;
                end
                S_TRAIL: begin
                    if (bus.m_ready && r_overlen_flag) r_err_overlen <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready     = w_s_ready;
    assign bus.m_valid     = w_m_valid;
    assign bus.m_last      = w_m_last;
    assign bus.m_data      = w_m_data;
    assign bus.crc_enable  = w_crc_enable;
    assign bus.crc_clr     = w_crc_clr;
    assign bus.crc_in      = r_hold;
    assign bus.err_timeout = r_err_timeout;
    assign bus.err_overlen = r_err_overlen;
endmodule

// File: tb/tb_crc8_tx_framer.sv
// Directed bench for crc8_tx_framer: a CRC-8 (poly 0x07) engine model with
// programmable latency, an output monitor, a frame table and corner-case sequences.
module tb_crc8_tx_framer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc8_tx_framer_if bus();

    crc8_tx_framer #(.SOF(8'h7E), .MAX_LEN(4), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Engine model: latency 0 means the engine never completes.
    int         eng_lat = 0;
    logic       eng_ovr = 1'b0;
    logic [7:0] eng_ovr_val = 8'h00;
    logic [7:0] eng_crc;
    int         eng_cd = 0;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            eng_crc <= 8'h00;
            eng_cd  <= 0;
        end else begin
            if (bus.crc_clr) eng_crc <= 8'h00;
            if (bus.crc_enable) begin
                eng_crc <= crc8_step(eng_crc, bus.crc_in);
                eng_cd  <= eng_lat;
            end else if (eng_cd > 0) begin
                eng_cd <= eng_cd - 1;
            end
        end
    end

    assign bus.crc_complete = (eng_cd == 1);
    assign bus.crc_out      = eng_ovr ? eng_ovr_val : eng_crc;

    // Monitor: accepted output bytes, pulse counts, stall stability.
    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];
    int n_clr, n_en, n_to, n_ol, cyc, en_cyc, to_cyc;
    logic       prev_stall;
    logic [8:0] prev_out;

    initial begin
        n_clr = 0; n_en = 0; n_to = 0; n_ol = 0; cyc = 0; en_cyc = 0; to_cyc = 0;
        prev_stall = 1'b0; prev_out = 9'h000;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stable_valid", 32'(bus.m_valid), 32'd1);
                    chk("stable_out", 32'({bus.m_last, bus.m_data}), 32'(prev_out));
                end
                if (bus.m_valid && bus.m_ready) obs_q.push_back({bus.m_last, bus.m_data});
                if (bus.crc_clr) n_clr++;
                if (bus.crc_enable) begin n_en++; en_cyc = cyc; end
                if (bus.err_timeout) begin n_to++; to_cyc = cyc; end
                if (bus.err_overlen) n_ol++;
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_out   = {bus.m_last, bus.m_data};
            end
        end
    end

    function automatic logic [22:0] outs();
        return {bus.s_ready, bus.m_data, bus.m_valid, bus.m_last, bus.crc_in,
                bus.crc_enable, bus.crc_clr, bus.err_timeout, bus.err_overlen};
    endfunction

    task automatic begin_frame();
        obs_q.delete();
        exp_q.delete();
        n_clr = 0; n_en = 0; n_to = 0; n_ol = 0;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l, output logic ok);
        ok = 1'b0;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        for (int k = 0; k < 500 && obs_q.size() < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input string name);
        chk({name, "_len"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            chk($sformatf("%s_b%0d", name, k), 32'(obs_q[k]), 32'(exp_q[k]));
    endtask

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][7:0] d;
        logic [7:0]      lat;
        logic            ovr;
        logic [7:0]      exp_crc;
    } frame_t;

    frame_t tbl [6];
    logic   ok;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'd1, 32'h000000AE, 8'd8, 1'b1, 8'h5C};
        tbl[1] = '{3'd1, 32'h00000001, 8'd1, 1'b0, 8'h07};
        tbl[2] = '{3'd2, 32'h00000201, 8'd3, 1'b0, 8'h1B};
        tbl[3] = '{3'd3, 32'h00030201, 8'd2, 1'b0, 8'h48};
        tbl[4] = '{3'd4, 32'h04030201, 8'd1, 1'b0, 8'hE3};
        tbl[5] = '{3'd1, 32'h00000010, 8'd5, 1'b0, 8'h70};

        rst = 1'b1;
        bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b0;

        // Reset with random inputs
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.s_data  = 8'($urandom);
            bus.s_valid = 1'($urandom);
            bus.s_last  = 1'($urandom);
            bus.m_ready = 1'($urandom);
            @(negedge clk);
            chk($sformatf("rst_outs%0d", c), 32'(outs()), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
        @(negedge clk);
        chk("rst_outs_last", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_outs", 32'(outs()), 32'd0);

        // Frame table, m_ready held high
        for (int i = 0; i < 6; i++) begin
            begin_frame();
            eng_lat     = int'(tbl[i].lat);
            eng_ovr     = tbl[i].ovr;
            eng_ovr_val = tbl[i].exp_crc;
            exp_q.push_back(9'h07E);
            for (int b = 0; b < int'(tbl[i].n); b++) begin
                push_byte(tbl[i].d[b], b == int'(tbl[i].n) - 1, ok);
                chk($sformatf("f%0d_accept%0d", i, b), 32'(ok), 32'd1);
                exp_q.push_back({1'b0, tbl[i].d[b]});
            end
            exp_q.push_back({1'b1, tbl[i].exp_crc});
            wait_obs(exp_q.size());
            repeat (3) @(posedge clk);
            #1;
            check_obs($sformatf("f%0d", i));
            chk($sformatf("f%0d_clr", i), n_clr, 1);
            chk($sformatf("f%0d_en", i), n_en, int'(tbl[i].n));
            chk($sformatf("f%0d_errs", i), n_to + n_ol, 0);
        end
        eng_ovr = 1'b0;

        // Back-pressure: m_ready toggles every 2 cycles
        begin_frame();
        eng_lat = 2;
        bus.m_ready = 1'b0;
        exp_q = '{9'h07E, 9'h001, 9'h002, 9'h003, 9'h148};
        begin
            logic bp_stop;
            bp_stop = 1'b0;
            fork
                begin
                    logic ok_a;
                    push_byte(8'h01, 1'b0, ok_a);
                    chk("bp_accept0", 32'(ok_a), 32'd1);
                    push_byte(8'h02, 1'b0, ok_a);
                    chk("bp_accept1", 32'(ok_a), 32'd1);
                    push_byte(8'h03, 1'b1, ok_a);
                    chk("bp_accept2", 32'(ok_a), 32'd1);
                    wait_obs(5);
                    bp_stop = 1'b1;
                end
                begin
                    for (int c = 1; c < 800 && !bp_stop; c++) begin
                        @(posedge clk); #1;
                        if (c % 2 == 0) bus.m_ready = !bus.m_ready;
                    end
                end
            join
        end
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_obs("bp");
        chk("bp_clr", n_clr, 1);
        chk("bp_en", n_en, 3);

        // Engine timeout
        begin_frame();
        eng_lat = 0;
        push_byte(8'h5A, 1'b1, ok);
        chk("to_accept", 32'(ok), 32'd1);
        for (int k = 0; k < 100 && n_to == 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("to_count", n_to, 1);
        chk("to_delay", to_cyc - en_cyc, 17);
        chk("to_en", n_en, 1);
        exp_q = '{9'h07E};
        check_obs("to_obs");
        chk("to_idle", 32'({bus.s_ready, bus.m_valid}), 32'd0);

        begin_frame();
        eng_lat = 1;
        push_byte(8'h01, 1'b1, ok);
        chk("after_to_accept", 32'(ok), 32'd1);
        exp_q = '{9'h07E, 9'h001, 9'h107};
        wait_obs(3);
        repeat (3) @(posedge clk);
        #1;
        check_obs("after_to");
        chk("after_to_clr", n_clr, 1);

        // Over-length: MAX_LEN=4, six bytes without s_last
        begin_frame();
        eng_lat = 1;
        for (int b = 1; b <= 6; b++) begin
            push_byte(8'(b), 1'b0, ok);
            chk($sformatf("ovl_accept%0d", b), 32'(ok), 32'd1);
        end
        exp_q = '{9'h07E, 9'h001, 9'h002, 9'h003, 9'h004, 9'h1E3, 9'h07E, 9'h005, 9'h006};
        wait_obs(9);
        repeat (3) @(posedge clk);
        #1;
        check_obs("ovl");
        chk("ovl_err", n_ol, 1);
        chk("ovl_clr", n_clr, 2);
        chk("ovl_en", n_en, 6);
        chk("ovl_to", n_to, 0);

        // Reset during WAIT of byte 2
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        begin_frame();
        eng_lat = 3;
        push_byte(8'hA1, 1'b0, ok);
        chk("rm_accept1", 32'(ok), 32'd1);
        wait_obs(2);
        eng_lat = 0;
        push_byte(8'hA2, 1'b0, ok);
        chk("rm_accept2", 32'(ok), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("rm_en", n_en, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rm_outs", 32'(outs()), 32'd0);
        rst = 1'b0;
        begin_frame();
        repeat (25) @(posedge clk);
        #1;
        chk("rm_quiet_obs", obs_q.size(), 0);
        chk("rm_quiet_err", n_to + n_ol, 0);

        begin_frame();
        eng_lat = 2;
        push_byte(8'h01, 1'b1, ok);
        chk("rm_next_accept", 32'(ok), 32'd1);
        exp_q = '{9'h07E, 9'h001, 9'h107};
        wait_obs(3);
        repeat (3) @(posedge clk);
        #1;
        check_obs("rm_next");
        chk("rm_next_clr", n_clr, 1);
        chk("rm_next_en", n_en, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
